// File: rtl/prim_arbiter_rr8.sv
// Eight-way round-robin arbiter with hold-until-release grants and a rotating priority pointer.
// Optional forced release after TIMEOUT_CYC grant cycles when PRIM_ARB_TIMEOUT_EN is defined.
module prim_arbiter_rr8 #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_req,
    input  logic       i_release,
    output logic [7:0] o_gnt,
    output logic [2:0] o_gnt_id,
    output logic       o_gnt_vld,
    output logic       o_timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] id_q, id_d;
    logic       vld_q, vld_d;
    logic [7:0] gnt_q, gnt_d;

    logic [2:0] search_ptr;
    logic       pick_found;
    logic [2:0] pick_idx;
    logic       owner_release;
    logic       timeout_hit;
    logic       release_evt;

`ifdef PRIM_ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        to_q, to_d;

    assign timeout_hit = (cnt_q == HOLD_LAST);
`else
    logic cfg_unused;

    assign cfg_unused  = (TIMEOUT_CYC < 2);
    assign timeout_hit = 1'b0;
`endif

    // Lowest rotation distance from ptr wins; scanning far-to-near leaves the nearest hit.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // A release moves the pointer past the owner, so the search uses that new pointer immediately.
    assign search_ptr    = (state_q == GRANT) ? (id_q + 3'd1) : ptr_q;
    assign {pick_found, pick_idx} = rr_pick(i_req, search_ptr);
    assign owner_release = i_release | ~i_req[id_q];
    assign release_evt   = owner_release | timeout_hit;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        vld_d   = vld_q;
`ifdef PRIM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    id_d    = pick_idx;
                    vld_d   = 1'b1;
`ifdef PRIM_ARB_TIMEOUT_EN
                    cnt_d   = 16'd0;
`endif
                end
            end
            GRANT: begin
                if (release_evt) begin
                    ptr_d = search_ptr;
`ifdef PRIM_ARB_TIMEOUT_EN
                    to_d  = timeout_hit & ~owner_release;
                    cnt_d = 16'd0;
`endif
                    if (pick_found) begin
                        state_d = GRANT;
                        id_d    = pick_idx;
                        vld_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        id_d    = 3'd0;
                        vld_d   = 1'b0;
                    end
                end else begin
`ifdef PRIM_ARB_TIMEOUT_EN
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                id_d    = 3'd0;
                vld_d   = 1'b0;
            end
        endcase
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_gnt_dec
        assign gnt_d[gi] = vld_d & (id_d == 3'(gi));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            id_q    <= 3'd0;
            vld_q   <= 1'b0;
            gnt_q   <= 8'h00;
`ifdef PRIM_ARB_TIMEOUT_EN
            cnt_q   <= 16'd0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            vld_q   <= vld_d;
            gnt_q   <= gnt_d;
`ifdef PRIM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_id  = id_q;
    assign o_gnt_vld = vld_q;
`ifdef PRIM_ARB_TIMEOUT_EN
    assign o_timeout = to_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_prim_arbiter_rr8.sv
// Directed bench for prim_arbiter_rr8: a driver queues the expected post-edge outputs per cycle,
// and a monitor pops and compares them one cycle at a time.
module tb_prim_arbiter_rr8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       tmo;

    typedef struct {
        logic [2:0] id;
        logic       vld;
        logic       to;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    prim_arbiter_rr8 #(.TIMEOUT_CYC(4)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_release(rel),
        .o_gnt    (gnt),
        .o_gnt_id (gnt_id),
        .o_gnt_vld(gnt_vld),
        .o_timeout(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus, with the outputs expected just after the following rising edge.
    task automatic step(input logic [7:0] r, input logic rl, input logic rs,
                        input logic [2:0] eid, input logic evld, input logic eto, input string nm);
        exp_t e;
        @(negedge clk);
        req = r;
        rel = rl;
        rst = rs;
        e.id   = eid;
        e.vld  = evld;
        e.to   = eto;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t       e;
        logic [7:0] egnt;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                egnt = e.vld ? (8'h01 << e.id) : 8'h00;
                n_cmp++;
                if (gnt_id !== e.id || gnt_vld !== e.vld || gnt !== egnt || tmo !== e.to) begin
                    n_bad++;
                    $display("FAIL %s: got id=%0d vld=%0b gnt=%02h to=%0b, want id=%0d vld=%0b gnt=%02h to=%0b",
                             e.name, gnt_id, gnt_vld, gnt, tmo, e.id, e.vld, egnt, e.to);
                end else begin
                    $display("ok   %s: id=%0d vld=%0b gnt=%02h to=%0b", e.name, gnt_id, gnt_vld, gnt, tmo);
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no finish, want finish before 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        req = 8'h00;
        rel = 1'b0;
        rst = 1'b1;

        step(8'h00, 0, 1, 0, 0, 0, "reset0");
        step(8'hFF, 1, 1, 0, 0, 0, "reset1");

        step(8'h24, 0, 0, 2, 1, 0, "basic_grant");
        step(8'h00, 0, 0, 0, 0, 0, "drop_to_idle");
        step(8'h00, 1, 0, 0, 0, 0, "idle_release_ignored");
        step(8'h00, 0, 0, 0, 0, 0, "idle_hold");

        step(8'h81, 0, 1, 0, 0, 0, "reset_before_wrap");
        step(8'h81, 0, 0, 0, 1, 0, "wrap_own0_a");
        step(8'h81, 1, 0, 7, 1, 0, "wrap_own7_a");
        step(8'h81, 1, 0, 0, 1, 0, "wrap_own0_b");
        step(8'h81, 1, 0, 7, 1, 0, "wrap_own7_b");
        step(8'h81, 0, 0, 7, 1, 0, "wrap_hold7");
        step(8'h80, 1, 0, 7, 1, 0, "sole_requester_regrant");

        step(8'h00, 0, 0, 0, 0, 0, "drop7_idle");
        step(8'h08, 0, 0, 3, 1, 0, "grant3");
        step(8'h00, 0, 0, 0, 0, 0, "drop3_idle");
        step(8'h18, 0, 0, 4, 1, 0, "ptr4_grant4");

        step(8'h20, 1, 0, 5, 1, 0, "grant5");
        for (int i = 0; i < 3; i++) begin
            step(8'hFF, 0, 0, 5, 1, 0, "no_preempt5");
        end
        step(8'hFF, 1, 0, 6, 1, 0, "release5_next6");

        step(8'hFF, 1, 1, 0, 0, 0, "reset_mid_grant");
        step(8'hFF, 0, 0, 0, 1, 0, "after_reset_own0");

        step(8'h03, 0, 1, 0, 0, 0, "reset_before_timeout");
`ifdef PRIM_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            step(8'h03, 0, 0, 0, 1, 0, "tmo_hold0");
        end
        step(8'h03, 0, 0, 1, 1, 1, "tmo_pulse_own1");
        for (int i = 0; i < 3; i++) begin
            step(8'h03, 0, 0, 1, 1, 0, "tmo_hold1");
        end
        step(8'h03, 1, 0, 0, 1, 0, "tmo_masked_by_release");
`else
        for (int i = 0; i < 100; i++) begin
            step(8'h03, 0, 0, 0, 1, 0, "hold0_no_timeout");
        end
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
